// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types for the instruction fetch front end.
//   fetch_state_t  : states of the fetch handshake sequencer
//   redirect_src_t : which redirect source won arbitration this cycle
//   FETCH_STRIDE   : byte distance between sequential fetches
// -----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_TRAP   = 2'd1,
        RD_BRANCH = 2'd2,
        RD_JUMP   = 2'd3
    } redirect_src_t;

    // Compressed-instruction realignment happens downstream, so the
    // sequential stride is always one full word.
    localparam int unsigned FETCH_STRIDE = 32'd4;

endpackage

// File: rtl/fetch_sequencer_redirect_arbiter.sv
// -----------------------------------------------------------------------------
// redirect_arbiter
// Combinational fixed-priority selector for PC redirects: trap > branch > jump.
// Ports:
//   i_trap / i_trap_target       trap or mret redirect and its target
//   i_branch / i_branch_target   taken branch from EX and its target
//   i_jump / i_jump_target       JAL/JALR from ID and its target
//   o_src                        winning source (RD_NONE when no redirect)
//   o_target                     target of the winning source (0 when none)
// -----------------------------------------------------------------------------
module redirect_arbiter
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                i_trap,
    input  logic [WIDTH-1:0]    i_trap_target,
    input  logic                i_branch,
    input  logic [WIDTH-1:0]    i_branch_target,
    input  logic                i_jump,
    input  logic [WIDTH-1:0]    i_jump_target,
    output redirect_src_t       o_src,
    output logic [WIDTH-1:0]    o_target
);

    // Fixed-priority selection of the redirect source and its target.
    always_comb begin
        o_src    = RD_NONE;
        o_target = {WIDTH{1'b0}};
        if (i_trap) begin
            o_src    = RD_TRAP;
            o_target = i_trap_target;
        end else if (i_branch) begin
            o_src    = RD_BRANCH;
            o_target = i_branch_target;
        end else if (i_jump) begin
            o_src    = RD_JUMP;
            o_target = i_jump_target;
        end else begin
            o_src    = RD_NONE;
            o_target = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// IF-stage fetch controller. Owns the fetch PC, runs a single-outstanding
// request/grant/response handshake with instruction memory, arbitrates PC
// redirects against sequential fetch and hands words to IF/ID with valid/ready.
// Ports:
//   clk_i, rst_n_i                   clock, asynchronous active-low reset
//   fetch_enable_i, boot_addr_i      start fetching; PC loaded on first enable
//   trap_i/branch_taken_i/jump_i     redirect requests (+ *_target_i)
//   instr_req_o, instr_addr_o        bus request and word-aligned address
//   instr_gnt_i, instr_rvalid_i,
//   instr_rdata_i                    bus grant and response
//   instr_o, pc_o, valid_o, ready_i  IF/ID delivery handshake
//   flush_o                          one-cycle pulse per redirect
// -----------------------------------------------------------------------------
module fetch_sequencer
    import core_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                fetch_enable_i,
    input  logic [WIDTH-1:0]    boot_addr_i,
    input  logic                trap_i,
    input  logic [WIDTH-1:0]    trap_target_i,
    input  logic                branch_taken_i,
    input  logic [WIDTH-1:0]    branch_target_i,
    input  logic                jump_i,
    input  logic [WIDTH-1:0]    jump_target_i,
    output logic                instr_req_o,
    output logic [WIDTH-1:0]    instr_addr_o,
    input  logic                instr_gnt_i,
    input  logic                instr_rvalid_i,
    input  logic [WIDTH-1:0]    instr_rdata_i,
    output logic [WIDTH-1:0]    instr_o,
    output logic [WIDTH-1:0]    pc_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                flush_o
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   w_pc_next;
    logic [WIDTH-1:0]   w_pc_incr;
    logic [WIDTH-1:0]   r_req_addr;
    logic [WIDTH-1:0]   w_req_addr_next;
    logic               r_discard;
    logic               w_discard_next;
    logic               r_booted;
    logic               w_booted_next;
    logic               r_valid;
    logic               w_valid_next;
    logic               w_capture;
    logic [WIDTH-1:0]   r_instr;
    logic [WIDTH-1:0]   r_pc_out;
    logic               r_flush;
    logic               w_req;

    redirect_src_t      w_redir_src;
    logic [WIDTH-1:0]   w_redir_target;
    logic               w_redir_valid;

    redirect_arbiter #(
        .WIDTH           (WIDTH)
    ) u_redirect_arbiter (
        .i_trap          (trap_i),
        .i_trap_target   (trap_target_i),
        .i_branch        (branch_taken_i),
        .i_branch_target (branch_target_i),
        .i_jump          (jump_i),
        .i_jump_target   (jump_target_i),
        .o_src           (w_redir_src),
        .o_target        (w_redir_target)
    );

    assign w_redir_valid = (w_redir_src != RD_NONE);
    // Wraps naturally modulo 2^WIDTH.
    assign w_pc_incr     = r_pc + WIDTH'(FETCH_STRIDE);

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-datapath decode for the fetch handshake.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_req_addr_next = r_req_addr;
        w_discard_next  = r_discard;
        w_booted_next   = r_booted;
        w_valid_next    = r_valid;
        w_capture       = 1'b0;
        case (r_state)
            FETCH_IDLE: begin
                if (w_redir_valid) begin
                    w_pc_next = w_redir_target;
                end else if (fetch_enable_i && !r_booted) begin
                    // Boot address only on the first enable after reset;
                    // later re-enables resume from the retained PC.
                    w_pc_next = boot_addr_i;
                end else begin
                    w_pc_next = r_pc;
                end
                if (fetch_enable_i) begin
                    w_state_next  = FETCH_REQ;
                    w_booted_next = 1'b1;
                end else begin
                    w_state_next  = FETCH_IDLE;
                end
            end
            FETCH_REQ: begin
                if (instr_gnt_i) begin
                    w_state_next    = FETCH_WAIT;
                    w_req_addr_next = r_pc;
                    if (w_redir_valid) begin
                        // The transaction just granted is already stale.
                        w_pc_next      = w_redir_target;
                        w_discard_next = 1'b1;
                    end else begin
                        w_pc_next      = w_pc_incr;
                    end
                end else if (w_redir_valid) begin
                    // Address may still change while the grant is pending.
                    w_pc_next = w_redir_target;
                end else begin
                    w_pc_next = r_pc;
                end
            end
            FETCH_WAIT: begin
                if (instr_rvalid_i) begin
                    if (r_discard || w_redir_valid) begin
                        w_discard_next = 1'b0;
                        w_state_next   = fetch_enable_i ? FETCH_REQ : FETCH_IDLE;
                        if (w_redir_valid) begin
                            w_pc_next = w_redir_target;
                        end else begin
                            w_pc_next = r_pc;
                        end
                    end else begin
                        w_capture    = 1'b1;
                        w_valid_next = 1'b1;
                        w_state_next = FETCH_HOLD;
                    end
                end else if (w_redir_valid) begin
                    // Keep waiting: the bus still owes us this response.
                    w_discard_next = 1'b1;
                    w_pc_next      = w_redir_target;
                end else begin
                    w_state_next = FETCH_WAIT;
                end
            end
            FETCH_HOLD: begin
                if (w_redir_valid) begin
                    w_valid_next = 1'b0;
                    w_pc_next    = w_redir_target;
                    w_state_next = fetch_enable_i ? FETCH_REQ : FETCH_IDLE;
                end else if (ready_i) begin
                    w_valid_next = 1'b0;
                    w_state_next = fetch_enable_i ? FETCH_REQ : FETCH_IDLE;
                end else begin
                    w_state_next = FETCH_HOLD;
                end
            end
            default: begin
                w_state_next   = FETCH_IDLE;
                w_discard_next = 1'b0;
                w_valid_next   = 1'b0;
            end
        endcase
    end

    // PC, in-flight address, discard flag and IF/ID output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc       <= RESET_PC;
            r_req_addr <= {WIDTH{1'b0}};
            r_discard  <= 1'b0;
            r_booted   <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= {WIDTH{1'b0}};
            r_pc_out   <= {WIDTH{1'b0}};
            r_flush    <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_req_addr <= w_req_addr_next;
            r_discard  <= w_discard_next;
            r_booted   <= w_booted_next;
            r_valid    <= w_valid_next;
            r_flush    <= w_redir_valid;
            if (w_capture) begin
                r_instr  <= instr_rdata_i;
                r_pc_out <= r_req_addr;
            end else begin
                r_instr  <= r_instr;
                r_pc_out <= r_pc_out;
            end
        end
    end

    // Output decode: request is a pure function of the state register.
    always_comb begin
        w_req = 1'b0;
        if (r_state == FETCH_REQ) begin
            w_req = 1'b1;
        end else begin
            w_req = 1'b0;
        end
    end

    assign instr_req_o  = w_req;
    assign instr_addr_o = {r_pc[WIDTH-1:2], 2'b00};
    assign instr_o      = r_instr;
    assign pc_o         = r_pc_out;
    assign valid_o      = r_valid;
    assign flush_o      = r_flush;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench: directed scenarios followed by a randomized run.
// The reference model tracks, per clock edge, the next fetch address, the
// outstanding bus transaction (with a stale mark) and the pending delivery.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int W = 32;

    logic           clk_i = 1'b0;
    logic           rst_n_i;
    logic           fetch_enable_i;
    logic [W-1:0]   boot_addr_i;
    logic           trap_i;
    logic [W-1:0]   trap_target_i;
    logic           branch_taken_i;
    logic [W-1:0]   branch_target_i;
    logic           jump_i;
    logic [W-1:0]   jump_target_i;
    logic           instr_req_o;
    logic [W-1:0]   instr_addr_o;
    logic           instr_gnt_i;
    logic           instr_rvalid_i;
    logic [W-1:0]   instr_rdata_i;
    logic [W-1:0]   instr_o;
    logic [W-1:0]   pc_o;
    logic           valid_o;
    logic           ready_i;
    logic           flush_o;

    fetch_sequencer #(
        .WIDTH           (W),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .fetch_enable_i  (fetch_enable_i),
        .boot_addr_i     (boot_addr_i),
        .trap_i          (trap_i),
        .trap_target_i   (trap_target_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .flush_o         (flush_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] addr;
        bit           stale;
    } txn_t;

    txn_t           q[$];
    logic [W-1:0]   gnt_log[$];
    logic [W-1:0]   dlv_log[$];
    logic [W-1:0]   model_pc;
    logic [W-1:0]   exp_pc;
    logic [W-1:0]   exp_instr;
    bit             booted;
    bit             exp_valid;
    bit             exp_flush;
    int             flush_cnt;
    int             req_cnt;
    int             gnt_wait;
    int             lat_cnt;
    int             gw_min, gw_max, lat_min, lat_max;
    int             n_vec;
    int             n_err;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare the current cycle against the model, then advance the model
    // by the effect of the coming clock edge.
    task automatic model_step();
        logic         redir;
        logic [W-1:0] tgt;
        bit           exp_req;
        txn_t         e;
        redir = trap_i | branch_taken_i | jump_i;
        tgt   = trap_i ? trap_target_i : (branch_taken_i ? branch_target_i : jump_target_i);

        check_val("flush", {31'd0, flush_o}, {31'd0, exp_flush});
        check_val("valid", {31'd0, valid_o}, {31'd0, exp_valid});
        if (exp_valid) begin
            check_val("pc_o", pc_o, exp_pc);
            check_val("instr_o", instr_o, exp_instr);
        end
        exp_req = booted && (q.size() == 0) && !exp_valid;
        check_val("req", {31'd0, instr_req_o}, {31'd0, exp_req});
        if (instr_req_o && exp_req) begin
            check_val("addr", instr_addr_o, model_pc & 32'hFFFF_FFFC);
        end
        if (flush_o) flush_cnt++;

        exp_flush = redir;
        if (!booted) begin
            if (redir) model_pc = tgt;
            else if (fetch_enable_i) model_pc = boot_addr_i;
            if (fetch_enable_i) booted = 1'b1;
        end else begin
            if (instr_req_o && instr_gnt_i) begin
                e.addr  = model_pc & 32'hFFFF_FFFC;
                e.stale = redir;
                q.push_back(e);
                gnt_log.push_back(e.addr);
                req_cnt  = 0;
                gnt_wait = $urandom_range(gw_max, gw_min);
                lat_cnt  = $urandom_range(lat_max, lat_min);
                model_pc = redir ? tgt : model_pc + 32'd4;
            end else begin
                if (instr_req_o) req_cnt++;
                if (redir) begin
                    model_pc = tgt;
                    if (q.size() > 0) q[0].stale = 1'b1;
                end
            end
            if (instr_rvalid_i && q.size() > 0) begin
                e = q.pop_front();
                if (!e.stale && !redir) begin
                    exp_valid = 1'b1;
                    exp_pc    = e.addr;
                    exp_instr = mem_word(e.addr);
                end
            end else if (exp_valid && (ready_i || redir)) begin
                exp_valid = 1'b0;
                if (!redir) dlv_log.push_back(exp_pc);
            end
        end
    endtask

    // Memory model: grant after gnt_wait request cycles, respond lat_cnt
    // cycles after the grant.
    task automatic bus_drive();
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = $urandom;
        if (q.size() > 0) begin
            if (lat_cnt == 0) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem_word(q[0].addr);
            end else begin
                lat_cnt--;
            end
        end
        instr_gnt_i = instr_req_o && (req_cnt >= gnt_wait);
    endtask

    task automatic cycle();
        @(negedge clk_i);
        if (rst_n_i) model_step();
        @(posedge clk_i);
        #1;
        bus_drive();
        trap_i         = 1'b0;
        branch_taken_i = 1'b0;
        jump_i         = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_i        = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        #1;
        check_val("rst_req",   {31'd0, instr_req_o}, 32'd0);
        check_val("rst_valid", {31'd0, valid_o}, 32'd0);
        check_val("rst_flush", {31'd0, flush_o}, 32'd0);
        check_val("rst_instr", instr_o, 32'd0);
        check_val("rst_pc",    pc_o, 32'd0);
        check_val("rst_addr",  instr_addr_o, 32'd0);
        q.delete();
        booted    = 1'b0;
        exp_valid = 1'b0;
        exp_flush = 1'b0;
        req_cnt   = 0;
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        bus_drive();
    endtask

    initial begin
        int mark;
        n_vec = 0; n_err = 0; flush_cnt = 0;
        rst_n_i = 1'b0; fetch_enable_i = 1'b0; boot_addr_i = 32'h8000_0000;
        trap_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0;
        trap_target_i = 32'd0; branch_target_i = 32'd0; jump_target_i = 32'd0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'd0;
        ready_i = 1'b1;
        gw_min = 1; gw_max = 1; lat_min = 1; lat_max = 1;
        gnt_wait = 1; lat_cnt = 1; req_cnt = 0; model_pc = 32'd0;
        #2;
        do_reset();

        // Sequential fetch from the boot address, with an IF/ID stall.
        fetch_enable_i = 1'b1;
        for (int k = 0; k < 100 && !valid_o; k++) cycle();
        check_val("t2_wait_valid", {31'd0, valid_o}, 32'd1);
        ready_i = 1'b0;
        repeat (3) begin
            cycle();
            check_val("t2_pc_hold", pc_o, 32'h8000_0000);
            check_val("t2_instr_hold", instr_o, mem_word(32'h8000_0000));
            check_val("t2_no_req", {31'd0, instr_req_o}, 32'd0);
        end
        ready_i = 1'b1;
        cycle();
        check_val("t2_resume", {31'd0, instr_req_o}, 32'd1);

        // Branch while 8000_0008 is outstanding.
        for (int k = 0; k < 100 && !(q.size() > 0 && q[0].addr == 32'h8000_0008 && !instr_rvalid_i); k++) cycle();
        check_val("t3_wait_out", {31'd0, (q.size() > 0 && !instr_rvalid_i)}, 32'd1);
        check_val("t1_req0", gnt_log[0], 32'h8000_0000);
        check_val("t1_req1", gnt_log[1], 32'h8000_0004);
        check_val("t1_req2", gnt_log[2], 32'h8000_0008);
        flush_cnt = 0;
        mark = gnt_log.size();
        branch_taken_i = 1'b1; branch_target_i = 32'h0000_0100;
        cycle();
        for (int k = 0; k < 100 && dlv_log.size() < 3; k++) cycle();
        check_val("t3_next_req", gnt_log[mark], 32'h0000_0100);
        check_val("t3_flush_cnt", flush_cnt, 32'd1);
        check_val("t3_dlv_cnt", dlv_log.size(), 32'd3);
        check_val("t1_dlv0", dlv_log[0], 32'h8000_0000);
        check_val("t1_dlv1", dlv_log[1], 32'h8000_0004);
        check_val("t3_dlv2", dlv_log[2], 32'h0000_0100);

        // Three simultaneous redirects while a request awaits grant.
        for (int k = 0; k < 100 && !(instr_req_o && !instr_gnt_i); k++) cycle();
        check_val("t4_wait_req", {31'd0, instr_req_o}, 32'd1);
        flush_cnt = 0;
        mark = gnt_log.size();
        trap_i = 1'b1; trap_target_i = 32'h0000_0040;
        branch_taken_i = 1'b1; branch_target_i = 32'h0000_0200;
        jump_i = 1'b1; jump_target_i = 32'h0000_0300;
        cycle();
        for (int k = 0; k < 100 && gnt_log.size() <= mark; k++) cycle();
        cycle();
        check_val("t4_next_req", gnt_log[mark], 32'h0000_0040);
        check_val("t4_flush_cnt", flush_cnt, 32'd1);

        // PC wrap at the top of the address space.
        boot_addr_i = 32'hFFFF_FFFC;
        do_reset();
        mark = gnt_log.size();
        for (int k = 0; k < 100 && gnt_log.size() < mark + 2; k++) cycle();
        check_val("t5_req0", gnt_log[mark], 32'hFFFF_FFFC);
        check_val("t5_req1", gnt_log[mark + 1], 32'h0000_0000);

        // Asynchronous reset while waiting for a response.
        for (int k = 0; k < 100 && q.size() == 0; k++) cycle();
        check_val("t6_in_wait", q.size(), 32'd1);
        boot_addr_i = 32'h0000_1000;
        #2;
        do_reset();
        mark = gnt_log.size();
        for (int k = 0; k < 100 && gnt_log.size() <= mark; k++) cycle();
        check_val("t6_boot_req", gnt_log[mark], 32'h0000_1000);

        // Randomized traffic, stalls and redirects.
        gw_min = 0; gw_max = 2; lat_min = 0; lat_max = 3;
        mark = dlv_log.size();
        for (int k = 0; k < 3000; k++) begin
            int r;
            ready_i = ($urandom_range(3, 0) != 0);
            r = $urandom_range(15, 0);
            if (r < 3) begin
                trap_i         = r[0];
                branch_taken_i = r[1];
                jump_i         = (r == 0) || ($urandom_range(1, 0) == 1);
                trap_target_i   = $urandom & 32'hFFFF_FFFC;
                branch_target_i = $urandom & 32'hFFFF_FFFC;
                jump_target_i   = $urandom & 32'hFFFF_FFFC;
            end
            cycle();
        end
        check_val("rand_progress", {31'd0, (dlv_log.size() > mark + 50)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
